// File: rtl/decode_pkg.sv
// Shared constants for the 6502-style microcoded decoder: enable bit indices,
// supported opcodes and the enable-vector width.
package decode_pkg;

  localparam int unsigned EN_WIDTH = 64;

  localparam int unsigned ADDR_RP       = 0;
  localparam int unsigned WRITE_EN      = 1;
  localparam int unsigned TIMING_RESET  = 2;
  localparam int unsigned PC_HOLD       = 3;
  localparam int unsigned ALU_A_OPERAND = 4;
  localparam int unsigned ALU_B_RA      = 5;
  localparam int unsigned ALU_OP_OR     = 6;
  localparam int unsigned ALU_OP_ADC    = 7;
  localparam int unsigned DATA_OUT_RA   = 8;
  localparam int unsigned PC_OPERAND    = 9;
  localparam int unsigned RA_ALU_OUT    = 10;
  localparam int unsigned RX_ALU_OUT    = 11;
  localparam int unsigned RY_ALU_OUT    = 12;
  localparam int unsigned RP_OPERAND    = 13;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_ORA_IMM = 8'h09;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;

endpackage

// File: rtl/decode_table.sv
// Pure combinational microcode table: (timing step, opcode) -> enables, plus an
// indicator that an undefined opcode is sitting in T0.
module decode_table
  import decode_pkg::*;
(
  input  logic [7:0]          timing,
  input  logic [7:0]          opcode,
  output logic [EN_WIDTH-1:0] enables,
  output logic                undef_t0
);

  logic one_hot;

  assign one_hot = (timing != 8'h00) && ((timing & (timing - 8'd1)) == 8'h00);

  always_comb begin
    enables  = '0;
    undef_t0 = 1'b0;
    if (one_hot) begin
      unique case (opcode)
        OP_NOP: begin
          if (timing[0]) enables[TIMING_RESET] = 1'b1;
        end
        OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: begin
          if (timing[1]) begin
            enables[ALU_A_OPERAND] = 1'b1;
            enables[ALU_OP_OR]     = 1'b1;
            enables[TIMING_RESET]  = 1'b1;
            enables[RA_ALU_OUT]    = (opcode == OP_LDA_IMM);
            enables[RX_ALU_OUT]    = (opcode == OP_LDX_IMM);
            enables[RY_ALU_OUT]    = (opcode == OP_LDY_IMM);
          end
        end
        OP_ORA_IMM, OP_ADC_IMM: begin
          if (timing[1]) begin
            enables[ALU_A_OPERAND] = 1'b1;
            enables[ALU_B_RA]      = 1'b1;
            enables[ALU_OP_OR]     = (opcode == OP_ORA_IMM);
            enables[ALU_OP_ADC]    = (opcode == OP_ADC_IMM);
            enables[RA_ALU_OUT]    = 1'b1;
            enables[TIMING_RESET]  = 1'b1;
          end
        end
        OP_JMP_ABS: begin
          if (timing[2]) begin
            enables[PC_OPERAND]   = 1'b1;
            enables[TIMING_RESET] = 1'b1;
          end
        end
        OP_STA_ABS: begin
          if (timing[2]) begin
            enables[RP_OPERAND] = 1'b1;
            enables[PC_HOLD]    = 1'b1;
          end
          if (timing[3]) begin
            enables[ADDR_RP]     = 1'b1;
            enables[WRITE_EN]    = 1'b1;
            enables[DATA_OUT_RA] = 1'b1;
            enables[PC_HOLD]     = 1'b1;
          end
          if (timing[4]) enables[TIMING_RESET] = 1'b1;
        end
        default: begin
          // Undefined opcodes behave as NOP here; the top decides whether to trap.
          if (timing[0]) begin
            enables[TIMING_RESET] = 1'b1;
            undef_t0              = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_logic.sv
// Decoder top: boot flag, optional sticky illegal-opcode trap and output gating.
// Trap enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_logic
  import decode_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          timing,
  input  logic [7:0]          opcode,
  output logic [EN_WIDTH-1:0] enables,
  output logic                illegal
);

  logic [EN_WIDTH-1:0] table_en;
  logic                undef_t0;
  logic                boot_q;
  logic                trap;

  decode_table u_table (
    .timing   (timing),
    .opcode   (opcode),
    .enables  (table_en),
    .undef_t0 (undef_t0)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) boot_q <= 1'b1;
    else        boot_q <= 1'b0;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Ignore the opcode register during boot; it has not been loaded yet.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    illegal_q <= 1'b0;
    else if (undef_t0 && !boot_q)  illegal_q <= 1'b1;
  end

  assign trap    = illegal_q || undef_t0;
  assign illegal = illegal_q;
`else
  assign trap    = 1'b0;
  assign illegal = 1'b0;
`endif

  always_comb begin
    enables = '0;
    if (!reset) begin
      enables = '0;
    end else if (boot_q) begin
      enables[TIMING_RESET] = 1'b1;
      enables[PC_HOLD]      = 1'b1;
    end else if (trap) begin
      enables[PC_HOLD] = 1'b1;
    end else begin
      enables = table_en;
    end
  end

  always_comb begin
    if (reset) begin
      assert (!(enables[ALU_OP_OR] && enables[ALU_OP_ADC]))
        else $error("multiple ALU_OP bits set");
      assert (!enables[WRITE_EN] || enables[ADDR_RP])
        else $error("WRITE_EN without ADDR_RP");
    end
  end

endmodule

// File: tb/tb_decode_logic.sv
// Directed-vector bench for decode_logic with hand-computed enable values.
module tb_decode_logic;

  logic        clock;
  logic        reset;
  logic [7:0]  timing;
  logic [7:0]  opcode;
  logic [63:0] enables;
  logic        illegal;

  int unsigned n_vec;
  int unsigned n_err;

  decode_logic dut (
    .clock   (clock),
    .reset   (reset),
    .timing  (timing),
    .opcode  (opcode),
    .enables (enables),
    .illegal (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [7:0] t, input logic [7:0] op);
    @(negedge clock);
    timing = t;
    opcode = op;
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    timing = 8'h01;
    opcode = 8'hEA;
    #12;
    check_eq("reset_enables", enables, 64'h0);
    check_eq("reset_illegal", {63'h0, illegal}, 64'h0);

    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("boot", enables, 64'h000C);
    apply(8'h01, 8'hEA);
    check_eq("nop_t0", enables, 64'h0004);

    apply(8'h01, 8'hA9);  check_eq("lda_t0", enables, 64'h0000);
    apply(8'h02, 8'hA9);  check_eq("lda_t1", enables, 64'h0454);
    apply(8'h02, 8'hA2);  check_eq("ldx_t1", enables, 64'h0854);
    apply(8'h02, 8'hA0);  check_eq("ldy_t1", enables, 64'h1054);
    apply(8'h02, 8'h09);  check_eq("ora_t1", enables, 64'h0474);
    apply(8'h02, 8'h69);  check_eq("adc_t1", enables, 64'h04B4);
    apply(8'h01, 8'h4C);  check_eq("jmp_t0", enables, 64'h0000);
    apply(8'h02, 8'h4C);  check_eq("jmp_t1", enables, 64'h0000);
    apply(8'h04, 8'h4C);  check_eq("jmp_t2", enables, 64'h0204);
    apply(8'h04, 8'h8D);  check_eq("sta_t2", enables, 64'h2008);
    apply(8'h08, 8'h8D);  check_eq("sta_t3", enables, 64'h010B);
    apply(8'h10, 8'h8D);  check_eq("sta_t4", enables, 64'h0004);
    apply(8'h20, 8'h8D);  check_eq("sta_t5", enables, 64'h0000);
    apply(8'h03, 8'hA9);  check_eq("multi_hot", enables, 64'h0000);
    apply(8'h00, 8'hA9);  check_eq("zero_timing", enables, 64'h0000);
    check_eq("no_illegal", {63'h0, illegal}, 64'h0);

    // Reset mid-instruction drops enables at once and re-runs boot.
    apply(8'h08, 8'h8D);
    reset = 1'b0;
    #1;
    check_eq("mid_reset", enables, 64'h0000);
    @(negedge clock);
    reset  = 1'b1;
    timing = 8'h01;
    opcode = 8'hEA;
    #1;
    check_eq("reboot", enables, 64'h000C);
    apply(8'h01, 8'hEA);  check_eq("reboot_nop", enables, 64'h0004);

    apply(8'h01, 8'hFF);
`ifdef DECODE_ILLEGAL_TRAP_EN
    apply(8'h02, 8'hFF);
    check_eq("trap_illegal", {63'h0, illegal}, 64'h1);
    check_eq("trap_t1", enables, 64'h0008);
    apply(8'h01, 8'hEA);  check_eq("trap_nop", enables, 64'h0008);
    apply(8'h04, 8'h4C);  check_eq("trap_jmp", enables, 64'h0008);
    reset = 1'b0;
    #1;
    check_eq("trap_rst_en", enables, 64'h0000);
    check_eq("trap_rst_ill", {63'h0, illegal}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    apply(8'h01, 8'hEA);
    check_eq("trap_clear", enables, 64'h0004);
`else
    check_eq("undef_t0", enables, 64'h0004);
    check_eq("undef_ill", {63'h0, illegal}, 64'h0);
    apply(8'h02, 8'hFF);
    check_eq("undef_t1", enables, 64'h0000);
    check_eq("undef_ill_after", {63'h0, illegal}, 64'h0);
    apply(8'h01, 8'hEA);
    check_eq("after_undef_nop", enables, 64'h0004);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
